// File: rtl/adder_tree_feeder.sv
// Gathers a 64-word operand tile, drives Adder_tree until it reports valid, then streams the 8 results out.
// Latency: tree_en rises 1 cycle after the last word is accepted, out_valid 1 cycle after tree_valid; no overlap between tiles.
module adder_tree_feeder #(
  parameter int DW      = 32,
  parameter int N_IN    = 64,
  parameter int N_OUT   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          tree_en,
  output logic [DW-1:0] tree_data [0:N_IN-1],
  input  logic          tree_valid,
  input  logic [DW-1:0] tree_result [0:N_OUT-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          timeout_err
);

  localparam int WW = $clog2(N_IN);
  localparam int RW = $clog2(N_OUT);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] LAST_WR  = WW'(N_IN - 1);
  localparam logic [RW-1:0] LAST_RD  = RW'(N_OUT - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wr_idx;
  logic [RW-1:0] rd_idx;
  logic [CW-1:0] wait_cnt;
  logic [DW-1:0] opnd [0:N_IN-1];
  logic [DW-1:0] res  [0:N_OUT-1];
  logic          accept;
  logic          xfer;

  always_comb begin
    accept = (state == LOAD) && in_ready && in_valid;
    xfer   = (state == DRAIN) && out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  // A tree_valid coinciding with the last timeout cycle takes priority.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && wr_idx == LAST_WR) state_nxt = RUN;
      RUN:     if (tree_valid) state_nxt = DRAIN;
               else if (wait_cnt == LAST_CNT) state_nxt = LOAD;
      DRAIN:   if (xfer && rd_idx == LAST_RD) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    tree_en   = (state == RUN);
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && (rd_idx == LAST_RD);
    out_data  = res[rd_idx];
    busy      = (state != LOAD) || (wr_idx != '0);
  end

  assign tree_data = opnd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx      <= '0;
      rd_idx      <= '0;
      wait_cnt    <= '0;
      in_ready    <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N_IN; i++)  opnd[i] <= '0;
      for (int k = 0; k < N_OUT; k++) res[k]  <= '0;
    end else begin
      in_ready <= (state_nxt == LOAD);
      case (state)
        LOAD: begin
          if (accept) begin
            opnd[wr_idx] <= in_data;
            wr_idx       <= (wr_idx == LAST_WR) ? '0 : wr_idx + WW'(1);
          end
        end
        RUN: begin
          if (tree_valid) begin
            for (int k = 0; k < N_OUT; k++) res[k] <= tree_result[k];
            wait_cnt <= '0;
          end else if (wait_cnt == LAST_CNT) begin
            timeout_err <= 1'b1;
            wait_cnt    <= '0;
            wr_idx      <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (xfer) begin
            rd_idx   <= (rd_idx == LAST_RD) ? '0 : rd_idx + RW'(1);
            wr_idx   <= '0;
            wait_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder with a behavioural Adder_tree responder.
// Drives and samples on the falling clock edge.
module tb_adder_tree_feeder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        tree_en;
  logic [31:0] tree_data [0:63];
  logic        tree_valid;
  logic [31:0] tree_result [0:7];
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int tree_delay = 3;
  logic spur_req = 1'b0;
  logic [31:0] req [0:7];

  adder_tree_feeder #(.DW(32), .N_IN(64), .N_OUT(8), .TIMEOUT(256)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tree_en(tree_en), .tree_data(tree_data),
    .tree_valid(tree_valid), .tree_result(tree_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tree responder: valid on the tree_delay-th cycle of en (0 = never answers).
  initial begin
    int en_cnt;
    en_cnt = 0;
    tree_valid = 1'b0;
    for (int k = 0; k < 8; k++) tree_result[k] = '0;
    forever begin
      @(negedge clk);
      tree_valid = 1'b0;
      if (spur_req) begin
        tree_valid = 1'b1;
        for (int k = 0; k < 8; k++) tree_result[k] = 32'hdead_beef;
      end else if (tree_en) begin
        en_cnt++;
        if (en_cnt == tree_delay) begin
          tree_valid = 1'b1;
          for (int k = 0; k < 8; k++) begin
            tree_result[k] = '0;
            for (int j = 0; j < 8; j++) tree_result[k] = tree_result[k] + tree_data[8*k+j];
          end
        end
      end
      if (!tree_en) en_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic fill_exp(input int base);
    for (int k = 0; k < 8; k++) req[k] = 32'(8*base + 64*k + 28);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tree_en", tree_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_tree_data0", tree_data[0], 0);
    chk("rst_tree_data63", tree_data[63], 0);
    @(negedge clk);
    rst = 1'b1;
    chk("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_high", in_ready, 1);
  endtask

  // Leaves a 65th word offered after a full tile so the bench can see it refused.
  task automatic send_tile(input int base, input bit gaps, input int nwords);
    int i = 0;
    int guard = 0;
    while (i < nwords && guard < 2000) begin
      @(negedge clk);
      guard++;
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = 32'(base + i);
      if (in_valid && in_ready) begin
        if (i == 63) chk("en_before_last", tree_en, 0);
        i++;
      end
    end
    if (i < nwords) chk("load_bound", i, nwords);
    if (nwords == 64) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'd999;
      chk("en_latency", tree_en, 1);
      chk("run_in_ready", in_ready, 0);
      chk("run_busy", busy, 1);
      chk("tree_data0", tree_data[0], 32'(base));
      chk("tree_data37", tree_data[37], 32'(base + 37));
      chk("tree_data63", tree_data[63], 32'(base + 63));
    end
  endtask

  task automatic collect(input int n_stop, input bit stall);
    int idx = 0;
    int guard = 0;
    while (idx < n_stop && guard < 3000) begin
      @(negedge clk);
      guard++;
      out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      chk("hold_in_ready", in_ready, 0);
      if (out_valid) begin
        chk("out_data", out_data, req[idx]);
        chk("out_last", out_last, (idx == 7));
        if (out_ready) begin
          idx++;
          if (idx == 8) in_valid = 1'b0;
        end
      end
    end
    if (idx < n_stop) chk("drain_bound", idx, n_stop);
    if (n_stop == 8) begin
      @(negedge clk);
      out_ready = 1'b0;
      chk("done_out_valid", out_valid, 0);
      chk("done_in_ready", in_ready, 1);
      chk("done_busy", busy, 0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Words 0..63 back to back: sums 28, 92, ..., 476.
    tree_delay = 3;
    send_tile(0, 1'b0, 64);
    fill_exp(0);
    collect(8, 1'b0);

    // Random input gaps and output stalls.
    send_tile(5, 1'b1, 64);
    fill_exp(5);
    collect(8, 1'b1);

    // Spurious tree_valid while idle in LOAD.
    #1 spur_req = 1'b1;
    @(negedge clk);
    #1 spur_req = 1'b0;
    @(negedge clk);
    chk("spur_load_busy", busy, 0);
    chk("spur_load_en", tree_en, 0);
    chk("spur_load_out_valid", out_valid, 0);
    chk("spur_load_in_ready", in_ready, 1);
    chk("spur_load_result", out_data, req[0]);

    // Spurious tree_valid during DRAIN.
    send_tile(7, 1'b0, 64);
    fill_exp(7);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("spur_drain_reach", out_valid, 1);
    #1 spur_req = 1'b1;
    @(negedge clk);
    #1 spur_req = 1'b0;
    collect(8, 1'b0);

    // Tree never answers.
    tree_delay = 0;
    send_tile(0, 1'b0, 64);
    in_valid = 1'b0;
    n = 1;
    while (n < 400) begin
      @(negedge clk);
      if (tree_en) n++;
      else break;
    end
    chk("timeout_en_cycles", n, 256);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_in_ready", in_ready, 1);
    chk("timeout_busy", busy, 0);

    // Recovery tile keeps the sticky error.
    tree_delay = 3;
    send_tile(100, 1'b0, 64);
    fill_exp(100);
    collect(8, 1'b0);
    chk("timeout_err_sticky", timeout_err, 1);

    // Answer on exactly the 256th RUN cycle: no error.
    do_reset();
    tree_delay = 256;
    send_tile(3, 1'b0, 64);
    fill_exp(3);
    collect(8, 1'b0);
    chk("edge_no_timeout", timeout_err, 0);

    // Reset with 30 words loaded, then a fresh tile.
    tree_delay = 3;
    send_tile(50, 1'b0, 30);
    @(negedge clk);
    in_valid = 1'b0;
    do_reset();
    send_tile(11, 1'b0, 64);
    fill_exp(11);
    collect(8, 1'b0);

    // Reset while result 4 is on the output.
    send_tile(20, 1'b0, 64);
    fill_exp(20);
    collect(4, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("mid_drain_result4", out_data, req[4]);
    do_reset();
    @(negedge clk);
    chk("no_stale_out_valid", out_valid, 0);
    send_tile(0, 1'b0, 64);
    fill_exp(0);
    collect(8, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
